alu_sequencer: RTL

Instruction sequencer for the single-cycle datapath. Accepts 32-bit instruction words over a valid/ready handshake and reads source operands from an internal 8×8 register file. It drives the ALU's DATA1/DATA2/SELECT inputs, waits a fixed ALU latency, then writes the ALU RESULT back to the destination register. It is the operand-issuing, result-consuming end of the ALU interface.

---
 rtl/alu_pkg.sv | 64 ++++++
 rtl/alu_sequencer_reg_file.sv | 42 ++++
 rtl/alu_sequencer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared constants, instruction layout and helpers for alu_sequencer
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam int c_data_w   = 8;
    localparam int c_addr_w   = 3;
    localparam int c_num_regs = 8;

    localparam logic [7:0] c_op_loadi = 8'h00;
    localparam logic [7:0] c_op_mov   = 8'h01;
    localparam logic [7:0] c_op_add   = 8'h02;
    localparam logic [7:0] c_op_sub   = 8'h03;
    localparam logic [7:0] c_op_and   = 8'h04;
    localparam logic [7:0] c_op_or    = 8'h05;

    localparam logic [2:0] c_sel_fwd = 3'b000;
    localparam logic [2:0] c_sel_add = 3'b001;
    localparam logic [2:0] c_sel_and = 3'b010;
    localparam logic [2:0] c_sel_or  = 3'b011;

    localparam int c_opcode_lsb = 24;
    localparam int c_dest_lsb   = 16;
    localparam int c_src1_lsb   = 8;
    localparam int c_src2_lsb   = 0;
    localparam int c_imm_lsb    = 0;

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_exec = 1'b1;

    typedef struct packed {
        logic [7:0]          opcode;
        logic [c_addr_w-1:0] dest;
        logic [c_addr_w-1:0] src1;
        logic [c_addr_w-1:0] src2;
        logic [c_data_w-1:0] imm;
    } instr_t;

    function automatic instr_t decode(input logic [31:0] word);
        instr_t d;
        d.opcode = word[c_opcode_lsb +: 8];
        d.dest   = word[c_dest_lsb   +: c_addr_w];
        d.src1   = word[c_src1_lsb   +: c_addr_w];
        d.src2   = word[c_src2_lsb   +: c_addr_w];
        d.imm    = word[c_imm_lsb    +: c_data_w];
        return d;
    endfunction

    function automatic logic is_legal(input logic [7:0] opcode);
        return (opcode <= c_op_or);
    endfunction

    // Two's-complement negate, so sub can reuse the ALU adder.
    function automatic logic [c_data_w-1:0] negate(input logic [c_data_w-1:0] value);
        return ~value + 8'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_sequencer_reg_file.sv
// ============================================================================
// Module   : reg_file
// Purpose  : 8x8 register file, one synchronous write port, three async reads
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file
    import alu_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic [c_addr_w-1:0] waddr,
    input  logic [c_data_w-1:0] wdata,
    input  logic [c_addr_w-1:0] raddr1,
    input  logic [c_addr_w-1:0] raddr2,
    input  logic [c_addr_w-1:0] dbg_addr,
    output logic [c_data_w-1:0] rdata1,
    output logic [c_data_w-1:0] rdata2,
    output logic [c_data_w-1:0] dbg_data
);

    logic [c_data_w-1:0] r_regs [c_num_regs];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_num_regs; i++) begin
                r_regs[i] <= '0;
            end
        end else if (we) begin
            r_regs[waddr] <= wdata;
        end
    end

    assign rdata1   = r_regs[raddr1];
    assign rdata2   = r_regs[raddr2];
    assign dbg_data = r_regs[dbg_addr];

endmodule

`default_nettype wire

// File: rtl/alu_sequencer.sv
// ============================================================================
// Module   : alu_sequencer
// Purpose  : Issues register operands to an external ALU and writes back RESULT
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_sequencer
    import alu_pkg::*;
#(
    parameter int ALU_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [7:0]  data1,
    output logic [7:0]  data2,
    output logic [2:0]  select,
    input  logic [7:0]  result,
    output logic        done,
    output logic        illegal,
    input  logic [2:0]  dbg_addr,
    output logic [7:0]  dbg_data
);

    localparam logic [2:0] c_latency = 3'(ALU_LATENCY);

    logic [0:0]          r_state;
    logic [2:0]          r_cnt;
    logic [c_addr_w-1:0] r_dest;
    logic [c_data_w-1:0] r_data1;
    logic [c_data_w-1:0] r_data2;
    logic [2:0]          r_select;
    logic                r_done;
    logic                r_illegal;

    instr_t              w_dec;
    logic                w_xfer;
    logic                w_legal;
    logic                w_wb;
    logic [2:0]          w_cnt_next;
    logic [c_data_w-1:0] w_rs1;
    logic [c_data_w-1:0] w_rs2;
    logic [c_data_w-1:0] w_op1;
    logic [c_data_w-1:0] w_op2;
    logic [2:0]          w_sel;

    assign w_dec       = decode(instr);
    assign instr_ready = (r_state == c_st_idle);
    assign w_xfer      = instr_valid && instr_ready;
    assign w_legal     = is_legal(w_dec.opcode);
    assign w_cnt_next  = r_cnt + 3'd1;
    // Write-back lands on the edge where the counter would reach the latency.
    assign w_wb        = (r_state == c_st_exec) && (w_cnt_next == c_latency);

    reg_file u_reg_file (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (w_wb),
        .waddr    (r_dest),
        .wdata    (result),
        .raddr1   (w_dec.src1),
        .raddr2   (w_dec.src2),
        .dbg_addr (dbg_addr),
        .rdata1   (w_rs1),
        .rdata2   (w_rs2),
        .dbg_data (dbg_data)
    );

    always_comb begin
        w_op1 = '0;
        w_op2 = w_rs2;
        w_sel = c_sel_fwd;
        case (w_dec.opcode)
            c_op_loadi: w_op2 = w_dec.imm;
            c_op_mov:   w_op2 = w_rs2;
            c_op_add: begin
                w_op1 = w_rs1;
                w_sel = c_sel_add;
            end
            c_op_sub: begin
                w_op1 = w_rs1;
                w_op2 = negate(w_rs2);
                w_sel = c_sel_add;
            end
            c_op_and: begin
                w_op1 = w_rs1;
                w_sel = c_sel_and;
            end
            c_op_or: begin
                w_op1 = w_rs1;
                w_sel = c_sel_or;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
            r_cnt   <= '0;
            r_dest  <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_xfer && w_legal) begin
                        r_state <= c_st_exec;
                        r_cnt   <= '0;
                        r_dest  <= w_dec.dest;
                    end
                end
                c_st_exec: begin
                    r_cnt <= w_cnt_next;
                    if (w_wb) begin
                        r_state <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    // Operands stay on the bus until the next legal issue; illegal ones leave them alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data1   <= '0;
            r_data2   <= '0;
            r_select  <= c_sel_fwd;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            if (w_xfer && w_legal) begin
                r_data1  <= w_op1;
                r_data2  <= w_op2;
                r_select <= w_sel;
            end
            r_done    <= w_wb;
            r_illegal <= w_xfer && !w_legal;
        end
    end

    assign data1   = r_data1;
    assign data2   = r_data2;
    assign select  = r_select;
    assign done    = r_done;
    assign illegal = r_illegal;

endmodule

`default_nettype wire
